// File: rtl/spw_pkg.sv
// Shared SpaceWire transmit definitions: link modes, character kinds,
// control codes in send order, character lengths and encoding helpers.
package spw_pkg;

  // Transmit mode driven by the link-state FSM.
  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_NULLS    = 2'd1,
    MODE_FCT_NULL = 2'd2,
    MODE_RUN      = 2'd3
  } tx_mode_e;

  // Character selected for appending in a given cycle.
  typedef enum logic [2:0] {
    CK_NULL = 3'd0,
    CK_FCT  = 3'd1,
    CK_EOP  = 3'd2,
    CK_EEP  = 3'd3,
    CK_DATA = 3'd4,
    CK_TC   = 3'd5
  } char_kind_e;

  // Control codes packed LSB-first: bit0 is the first code bit on the wire.
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b10;
  localparam logic [1:0] CODE_EEP = 2'b01;
  localparam logic [1:0] CODE_ESC = 2'b11;

  localparam int unsigned WORD_W      = 8;
  localparam int unsigned BUF_W       = 24;
  localparam int unsigned LEVEL_W     = 5;
  localparam int unsigned CHAR_BITS_W = 14;
  localparam int unsigned LEN_W       = 4;

  localparam int unsigned LEN_CTRL = 4;
  localparam int unsigned LEN_NULL = 8;
  localparam int unsigned LEN_DATA = 10;
  localparam int unsigned LEN_TC   = 14;

  // Odd parity over the previous payload, this parity bit and this flag.
  function automatic logic char_parity(input logic prev_par, input logic flag);
    return ~(prev_par ^ flag);
  endfunction

  // Control character in send order: P, 1, code[0], code[1].
  function automatic logic [3:0] ctrl_char(input logic prev_par, input logic [1:0] code);
    return {code[1], code[0], 1'b1, char_parity(prev_par, 1'b1)};
  endfunction

  // Data character in send order: P, 0, d0..d7.
  function automatic logic [9:0] data_char(input logic prev_par, input logic [7:0] d);
    return {d, 1'b0, char_parity(prev_par, 1'b0)};
  endfunction

endpackage

// File: rtl/spw_char_encoder.sv
// Combinational character encoder. Produces the LSB-first bit pattern of the
// selected character (optionally preceded by a NULL), its length, and the
// parity of the last payload for chaining into the next character.
//   kind             in  character to encode
//   pad_null         in  prepend a NULL (used for short control chars)
//   data             in  data byte / time-code value
//   prev_parity      in  XOR of the previous character's payload
//   bits             out encoded bits, bit0 sent first
//   len              out number of valid bits in bits
//   next_prev_parity out payload parity after the last encoded character
module spw_char_encoder
  import spw_pkg::*;
(
  input  char_kind_e             kind,
  input  logic                   pad_null,
  input  logic [7:0]             data,
  input  logic                   prev_parity,
  output logic [CHAR_BITS_W-1:0] bits,
  output logic [LEN_W-1:0]       len,
  output logic                   next_prev_parity
);

  // Characters are concatenated at the running length, parity chained through each.
  always_comb begin
    bits             = '0;
    len              = '0;
    next_prev_parity = prev_parity;

    // ESC: first half of NULL and the prefix of a time-code.
    if (pad_null || kind == CK_NULL || kind == CK_TC) begin
      bits             = bits | (CHAR_BITS_W'(ctrl_char(next_prev_parity, CODE_ESC)) << len);
      len              = len + LEN_W'(LEN_CTRL);
      next_prev_parity = ^CODE_ESC;
    end

    // FCT: second half of NULL.
    if (pad_null || kind == CK_NULL) begin
      bits             = bits | (CHAR_BITS_W'(ctrl_char(next_prev_parity, CODE_FCT)) << len);
      len              = len + LEN_W'(LEN_CTRL);
      next_prev_parity = ^CODE_FCT;
    end

    case (kind)
      CK_FCT: begin
        bits             = bits | (CHAR_BITS_W'(ctrl_char(next_prev_parity, CODE_FCT)) << len);
        len              = len + LEN_W'(LEN_CTRL);
        next_prev_parity = ^CODE_FCT;
      end
      CK_EOP: begin
        bits             = bits | (CHAR_BITS_W'(ctrl_char(next_prev_parity, CODE_EOP)) << len);
        len              = len + LEN_W'(LEN_CTRL);
        next_prev_parity = ^CODE_EOP;
      end
      CK_EEP: begin
        bits             = bits | (CHAR_BITS_W'(ctrl_char(next_prev_parity, CODE_EEP)) << len);
        len              = len + LEN_W'(LEN_CTRL);
        next_prev_parity = ^CODE_EEP;
      end
      CK_DATA, CK_TC: begin
        bits             = bits | (CHAR_BITS_W'(data_char(next_prev_parity, data)) << len);
        len              = len + LEN_W'(LEN_DATA);
        next_prev_parity = ^data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spw_tx_scheduler.sv
// SpaceWire transmit scheduler for one channel. Picks one character per
// word-clock cycle by priority (time-code > FCT > N-char > NULL), encodes it
// with odd parity, packs it into a 24-bit LSB-first bit buffer and emits 8 bits
// per cycle on txmt (txmt[0] first on the wire).
//   tx_clk_div  in  parallel-word clock
//   rst         in  synchronous active-high reset
//   tx_mode     in  0 OFF, 1 NULLS, 2 FCT_NULL, 3 RUN
//   fct_req     in  queue one FCT
//   fct_rx      in  FCT received from peer, +8 credit
//   nchar_*     in/out N-char offer and accept strobe (combinational)
//   tc_*        in/out time-code offer and accept strobe (combinational)
//   txmt        out registered 8-bit word for the serializer
//   credit      out transmit credit
//   credit_err  out one-cycle pulse on credit overflow
//   fct_pending out queued, unsent FCTs
module spw_tx_scheduler
  import spw_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned CREDIT_MAX = 56,
  parameter int unsigned FCT_CNT_W  = 3
) (
  input  logic                 tx_clk_div,
  input  logic                 rst,
  input  logic [1:0]           tx_mode,
  input  logic                 fct_req,
  input  logic                 fct_rx,
  input  logic                 nchar_valid,
  input  logic [8:0]           nchar_data,
  output logic                 nchar_ready,
  input  logic                 tc_valid,
  input  logic [7:0]           tc_data,
  output logic                 tc_ready,
  output logic [7:0]           txmt,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 credit_err,
  output logic [FCT_CNT_W-1:0] fct_pending
);

  // Highest buffer level at which a character of each length still fits.
  localparam logic [LEVEL_W-1:0] TC_FIT_MAX   = LEVEL_W'(BUF_W + WORD_W - LEN_TC);
  localparam logic [LEVEL_W-1:0] DATA_FIT_MAX = LEVEL_W'(BUF_W + WORD_W - LEN_DATA);
  // Below this level a lone control char would starve the next word, so pad with NULL.
  localparam logic [LEVEL_W-1:0] PAD_LEVEL    = LEVEL_W'(WORD_W + LEN_CTRL);
  localparam logic [LEVEL_W-1:0] LEVEL_RST    = LEVEL_W'(WORD_W);

  logic [BUF_W-1:0]     bit_buf_q;
  logic [LEVEL_W-1:0]   level_q;
  logic                 prev_par_q;
  logic [7:0]           txmt_q;
  logic [CREDIT_W-1:0]  credit_q;
  logic                 credit_err_q;
  logic [FCT_CNT_W-1:0] fct_pending_q;

  tx_mode_e mode;
  logic     mode_off, fct_mode_ok, tc_want, fct_want, nchar_want;

  assign mode        = tx_mode_e'(tx_mode);
  assign mode_off    = (mode == MODE_OFF);
  assign fct_mode_ok = (mode == MODE_FCT_NULL) || (mode == MODE_RUN);
  assign tc_want     = (mode == MODE_RUN) && tc_valid;
  assign fct_want    = fct_mode_ok && (fct_pending_q != '0);
  assign nchar_want  = (mode == MODE_RUN) && nchar_valid && (credit_q != '0);

  char_kind_e kind_c;
  logic       pad_null_c;
  logic [7:0] enc_data_c;
  logic       fits_c;

  // Priority select and fit check; a non-fitting choice blocks lower priorities.
  always_comb begin
    kind_c     = CK_NULL;
    pad_null_c = 1'b0;
    enc_data_c = '0;
    fits_c     = 1'b1;
    if (tc_want) begin
      kind_c     = CK_TC;
      enc_data_c = tc_data;
      fits_c     = (level_q <= TC_FIT_MAX);
    end else if (fct_want) begin
      kind_c     = CK_FCT;
      pad_null_c = (level_q < PAD_LEVEL);
    end else if (nchar_want) begin
      if (nchar_data[8]) begin
        kind_c     = nchar_data[0] ? CK_EEP : CK_EOP;
        pad_null_c = (level_q < PAD_LEVEL);
      end else begin
        kind_c     = CK_DATA;
        enc_data_c = nchar_data[7:0];
        fits_c     = (level_q <= DATA_FIT_MAX);
      end
    end
  end

  logic [CHAR_BITS_W-1:0] enc_bits;
  logic [LEN_W-1:0]       enc_len;
  logic                   enc_next_par;

  spw_char_encoder u_enc (
    .kind             (kind_c),
    .pad_null         (pad_null_c),
    .data             (enc_data_c),
    .prev_parity      (prev_par_q),
    .bits             (enc_bits),
    .len              (enc_len),
    .next_prev_parity (enc_next_par)
  );

  logic append_c, fct_sent_c;

  assign append_c    = fits_c && !mode_off;
  assign tc_ready    = append_c && tc_want;
  assign fct_sent_c  = append_c && !tc_want && fct_want;
  assign nchar_ready = append_c && !tc_want && !fct_want && nchar_want;

  logic [BUF_W-1:0]     bit_buf_d;
  logic [LEVEL_W-1:0]   level_d;
  logic                 prev_par_d;
  logic                 credit_over_c;
  logic [CREDIT_W-1:0]  credit_d;
  logic                 fct_req_ok_c;
  logic [FCT_CNT_W-1:0] fct_pending_d;

  // Buffer shift/append, credit and pending-FCT arithmetic.
  always_comb begin
    level_d    = level_q - LEVEL_W'(WORD_W);
    bit_buf_d  = bit_buf_q >> WORD_W;
    prev_par_d = prev_par_q;
    if (append_c) begin
      bit_buf_d  = bit_buf_d | (BUF_W'(enc_bits) << level_d);
      level_d    = level_d + LEVEL_W'(enc_len);
      prev_par_d = enc_next_par;
    end

    credit_over_c = fct_rx && (credit_q > CREDIT_W'(CREDIT_MAX - 8));
    credit_d      = credit_q - CREDIT_W'(nchar_ready);
    if (fct_rx && !credit_over_c) begin
      credit_d = credit_d + CREDIT_W'(8);
    end

    fct_req_ok_c  = fct_req && fct_mode_ok && (fct_pending_q != '1);
    fct_pending_d = fct_pending_q + FCT_CNT_W'(fct_req_ok_c) - FCT_CNT_W'(fct_sent_c);
  end

  // State registers; OFF flushes the buffer and clears link counters.
  always_ff @(posedge tx_clk_div) begin
    if (rst) begin
      bit_buf_q     <= '0;
      level_q       <= LEVEL_RST;
      prev_par_q    <= 1'b0;
      txmt_q        <= '0;
      credit_q      <= '0;
      credit_err_q  <= 1'b0;
      fct_pending_q <= '0;
    end else if (mode_off) begin
      txmt_q        <= bit_buf_q[7:0];
      bit_buf_q     <= '0;
      level_q       <= LEVEL_RST;
      prev_par_q    <= 1'b0;
      credit_q      <= '0;
      credit_err_q  <= 1'b0;
      fct_pending_q <= '0;
    end else begin
      txmt_q        <= bit_buf_q[7:0];
      bit_buf_q     <= bit_buf_d;
      level_q       <= level_d;
      prev_par_q    <= prev_par_d;
      credit_q      <= credit_d;
      credit_err_q  <= credit_over_c;
      fct_pending_q <= fct_pending_d;
    end
  end

  assign txmt        = txmt_q;
  assign credit      = credit_q;
  assign credit_err  = credit_err_q;
  assign fct_pending = fct_pending_q;

endmodule

// File: tb/tb_spw_tx_scheduler.sv
// Directed bench for spw_tx_scheduler with hand-computed wire words.
module tb_spw_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx_mode;
  logic       fct_req, fct_rx;
  logic       nchar_valid;
  logic [8:0] nchar_data;
  logic       nchar_ready;
  logic       tc_valid;
  logic [7:0] tc_data;
  logic       tc_ready;
  logic [7:0] txmt;
  logic [5:0] credit;
  logic       credit_err;
  logic [2:0] fct_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spw_tx_scheduler #(.CREDIT_W(6), .CREDIT_MAX(56), .FCT_CNT_W(3)) dut (
    .tx_clk_div  (clk),
    .rst         (rst),
    .tx_mode     (tx_mode),
    .fct_req     (fct_req),
    .fct_rx      (fct_rx),
    .nchar_valid (nchar_valid),
    .nchar_data  (nchar_data),
    .nchar_ready (nchar_ready),
    .tc_valid    (tc_valid),
    .tc_data     (tc_data),
    .tc_ready    (tc_ready),
    .txmt        (txmt),
    .credit      (credit),
    .credit_err  (credit_err),
    .fct_pending (fct_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one word; outputs are stable 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; tx_mode = 2'd1; fct_req = 1'b0; fct_rx = 1'b0;
    nchar_valid = 1'b0; nchar_data = '0; tc_valid = 1'b0; tc_data = '0;

    // 1. reset, then NULLS mode
    tick; tick;
    chk("rst_txmt",        32'(txmt),        32'h00);
    chk("rst_credit",      32'(credit),      32'h00);
    chk("rst_fct_pending", 32'(fct_pending), 32'h00);
    chk("rst_credit_err",  32'(credit_err),  32'h0);
    chk("rst_nchar_ready", 32'(nchar_ready), 32'h0);
    chk("rst_tc_ready",    32'(tc_ready),    32'h0);
    rst = 1'b0;
    tick;
    chk("nulls_first_word", 32'(txmt), 32'h00);
    fct_req = 1'b1;
    tick;
    fct_req = 1'b0;
    chk("nulls_word1",       32'(txmt),        32'h2E);
    chk("nulls_fct_ignored", 32'(fct_pending), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("nulls_steady", 32'(txmt), 32'h2E);
    end

    // 2. credit accumulation and overflow
    tx_mode = 2'd3;
    fct_rx  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("credit_acc", 32'(credit),     (k <= 7) ? 32'(8 * k) : 32'd56);
      chk("credit_err", 32'(credit_err), (k == 8) ? 32'h1 : 32'h0);
    end
    fct_rx = 1'b0;
    tick;
    chk("credit_err_clear", 32'(credit_err), 32'h0);
    chk("credit_hold56",    32'(credit),     32'd56);

    // 3. zero credit blocks N-char; one FCT unblocks it
    tx_mode = 2'd0;
    tick;
    chk("off_credit0", 32'(credit), 32'h0);
    tx_mode = 2'd3; nchar_valid = 1'b1; nchar_data = 9'h000;
    #1 chk("nochar_ready0", 32'(nchar_ready), 32'h0);
    tick;
    chk("restart_word0", 32'(txmt), 32'h00);
    tick;
    chk("nocredit_null", 32'(txmt), 32'h2E);
    fct_rx = 1'b1;
    #1 chk("nochar_ready1", 32'(nchar_ready), 32'h0);
    tick;
    fct_rx = 1'b0;
    chk("credit_8", 32'(credit), 32'd8);
    #1 chk("nchar_ready_on", 32'(nchar_ready), 32'h1);
    tick;
    nchar_valid = 1'b0;
    chk("credit_7",      32'(credit), 32'd7);
    chk("pre_data_null", 32'(txmt),   32'h2E);
    tick;
    chk("data00_word", 32'(txmt), 32'h01);
    tick;
    chk("null_off2_a", 32'(txmt), 32'hB8);
    tick;
    chk("null_off2_b", 32'(txmt), 32'hB8);

    // 4. EOP at level 8 is padded with a NULL
    tx_mode = 2'd0;
    tick;
    tx_mode = 2'd3; fct_rx = 1'b1;
    tick;
    fct_rx = 1'b0;
    chk("eop_pre_word0", 32'(txmt), 32'h00);
    nchar_valid = 1'b1; nchar_data = 9'h100;
    #1 chk("eop_ready", 32'(nchar_ready), 32'h1);
    tick;
    nchar_valid = 1'b0;
    chk("eop_credit", 32'(credit), 32'd7);
    chk("eop_w1",     32'(txmt),   32'h2E);
    tick; chk("eop_w2", 32'(txmt), 32'h2E);
    tick; chk("eop_w3", 32'(txmt), 32'hFA);
    tick; chk("eop_w4", 32'(txmt), 32'hE2);
    tick; chk("eop_w5", 32'(txmt), 32'hE2);

    // 5. time-code, FCT and N-char offered together
    tc_valid = 1'b1; tc_data = 8'h01; fct_req = 1'b1;
    nchar_valid = 1'b1; nchar_data = 9'h055;
    #1;
    chk("prio_tc_ready",    32'(tc_ready),    32'h1);
    chk("prio_nchar_wait0", 32'(nchar_ready), 32'h0);
    tick;
    tc_valid = 1'b0; fct_req = 1'b0;
    chk("prio_pending1", 32'(fct_pending), 32'h1);
    chk("prio_w1",       32'(txmt),        32'hE2);
    #1;
    chk("prio_tc_ready_off", 32'(tc_ready),    32'h0);
    chk("prio_nchar_wait1",  32'(nchar_ready), 32'h0);
    tick;
    chk("prio_pending0", 32'(fct_pending), 32'h0);
    chk("prio_w2",       32'(txmt),        32'hE2);
    #1 chk("prio_nchar_ready", 32'(nchar_ready), 32'h1);
    tick;
    nchar_valid = 1'b0;
    chk("prio_w3",     32'(txmt),   32'h05);
    chk("prio_credit", 32'(credit), 32'd6);
    tick; chk("prio_w4", 32'(txmt), 32'h4C);
    tick; chk("prio_w5", 32'(txmt), 32'h55);
    tick; chk("prio_w6", 32'(txmt), 32'h2E);

    // 6. OFF in the middle of a time-code, then back to NULLS
    tc_valid = 1'b1; tc_data = 8'hA5;
    #1 chk("off_tc_ready", 32'(tc_ready), 32'h1);
    tick;
    tc_valid = 1'b0; tx_mode = 2'd0;
    tick;
    chk("off_credit",  32'(credit),      32'h0);
    chk("off_pending", 32'(fct_pending), 32'h0);
    tc_valid = 1'b1;
    #1 chk("off_tc_blocked", 32'(tc_ready), 32'h0);
    tick; chk("off_w1", 32'(txmt), 32'h00);
    tick; chk("off_w2", 32'(txmt), 32'h00);
    tc_valid = 1'b0; tx_mode = 2'd1;
    tick; chk("resume_w0", 32'(txmt), 32'h00);
    tick; chk("resume_w1", 32'(txmt), 32'h2E);
    tick; chk("resume_w2", 32'(txmt), 32'h2E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
